// File: rtl/demux_pkg.sv
// Shared constants, types and helpers for the registered 1-to-4 demultiplexer.
// The lane count and select width are fixed by the 2-bit select/pointer.
package demux_pkg;

  localparam int unsigned N_LANES = 4;
  localparam int unsigned SEL_W   = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // Round-robin step; the 2-bit width makes 3 -> 0 wrap for free.
  function automatic sel_t next_ptr(input sel_t ptr);
    return ptr + sel_t'(1);
  endfunction

endpackage

// File: rtl/demux_lane.sv
// One-entry holding buffer for a single output lane with a valid/ready handshake.
// A load in the same cycle as a drain replaces the word and keeps the lane valid.
module demux_lane #(
  parameter int unsigned n = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [n-1:0] d,
  input  logic         r,
  output logic [n-1:0] y,
  output logic         v,
  output logic         ready
);

  logic [n-1:0] y_q, y_d;
  logic         v_q, v_d;

  always_comb begin
    y_d = y_q;
    if (load) begin
      y_d = d;
    end
  end

  // Load wins over drain so back-to-back words stream at full rate.
  always_comb begin
    v_d = v_q;
    if (load) begin
      v_d = 1'b1;
    end else if (v_q && r) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_q <= '0;
      v_q <= 1'b0;
    end else begin
      y_q <= y_d;
      v_q <= v_d;
    end
  end

  assign y     = y_q;
  assign v     = v_q;
  assign ready = !v_q || r;

endmodule

// File: rtl/demux_1x4_nbits_seq.sv
// Registered 1-to-4 demultiplexer: steers one n-bit stream into four buffered lanes,
// selected either by s or by an internal round-robin pointer.
module demux_1x4_nbits_seq
  import demux_pkg::*;
#(
  parameter int unsigned n = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [n-1:0] d,
  input  logic [1:0]   s,
  input  logic         auto,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [n-1:0] y0,
  output logic [n-1:0] y1,
  output logic [n-1:0] y2,
  output logic [n-1:0] y3,
  output logic         v0,
  output logic         v1,
  output logic         v2,
  output logic         v3,
  input  logic         r0,
  input  logic         r1,
  input  logic         r2,
  input  logic         r3,
  output logic [1:0]   ptr
);

  logic [N_LANES-1:0] r_vec;
  logic [N_LANES-1:0] v_vec;
  logic [N_LANES-1:0] ready_vec;
  logic [N_LANES-1:0] load;
  logic [n-1:0]       y_vec [N_LANES];

  sel_t sel;
  sel_t ptr_q, ptr_d;
  logic accept;

  assign r_vec = {r3, r2, r1, r0};

  assign sel      = auto ? ptr_q : s;
  assign in_ready = ready_vec[sel];
  assign accept   = in_valid && in_ready;

  always_comb begin
    load = '0;
    for (int k = 0; k < N_LANES; k++) begin
      load[k] = accept && (sel == sel_t'(k));
    end
  end

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    demux_lane #(
      .n(n)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .load   (load[k]),
      .d      (d),
      .r      (r_vec[k]),
      .y      (y_vec[k]),
      .v      (v_vec[k]),
      .ready  (ready_vec[k])
    );
  end

  // Pointer moves only when auto mode actually hands a word to a lane; a stall never skips.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && auto) begin
      ptr_d = next_ptr(ptr_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

  assign y0 = y_vec[0];
  assign y1 = y_vec[1];
  assign y2 = y_vec[2];
  assign y3 = y_vec[3];

  assign v0 = v_vec[0];
  assign v1 = v_vec[1];
  assign v2 = v_vec[2];
  assign v3 = v_vec[3];

endmodule
